// File: rtl/npn_tt_sequencer.sv
// npn_tt_sequencer: walks the 16 minterms of an external 4-input function,
// applying an input-negation mask on the way out and an output negation on
// the way back. The resulting truth table is published on tt when the scan
// completes.
//
// Optional feature: define NPN_TT_SEQUENCER_CMP_EN to add the exp_tt input
// and the match output. With the macro defined, the captured table is
// compared against an expected table that is latched at start.
module npn_tt_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  neg_mask,
  input  logic        out_neg,
  output logic [3:0]  x,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt
`ifdef NPN_TT_SEQUENCER_CMP_EN
  ,
  input  logic [15:0] exp_tt,
  output logic        match
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // With SETTLE=0 the DRIVE phase disappears and each minterm is a single
  // SAMPLE cycle.
  localparam bit         SKIP_DRIVE  = (SETTLE == 0);
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam state_e     FIRST_PHASE = SKIP_DRIVE ? SAMPLE : DRIVE;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  mask_q, mask_d;
  logic        out_neg_q, out_neg_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] tt_q, tt_d;
`ifdef NPN_TT_SEQUENCER_CMP_EN
  logic [15:0] exp_q, exp_d;
  logic        match_q, match_d;
`endif

  // Next-state logic: sequence the minterm walk and decide what each
  // register captures.
  always_comb begin
    // NOTE: every target gets a default before the case statement. This
    // means any path that does not assign a signal simply holds its value,
    // instead of inferring a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    mask_d    = mask_q;
    out_neg_d = out_neg_q;
    shadow_d  = shadow_q;
    tt_d      = tt_q;
`ifdef NPN_TT_SEQUENCER_CMP_EN
    exp_d     = exp_q;
    match_d   = match_q;
`endif

    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort, because abort means nothing here.
        if (start) begin
          mask_d    = neg_mask;
          out_neg_d = out_neg;
          idx_d     = 4'd0;
          settle_d  = 4'd0;
          shadow_d  = '0;
`ifdef NPN_TT_SEQUENCER_CMP_EN
          exp_d     = exp_tt;
`endif
          state_d   = FIRST_PHASE;
        end
      end

      DRIVE: begin
        if (abort) begin
          settle_d = 4'd0;
          shadow_d = '0;
          state_d  = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      SAMPLE: begin
        if (abort) begin
          // abort beats the sample write, and the partial table is dropped.
          shadow_d = '0;
          state_d  = IDLE;
        end else begin
          // The shadow is indexed by the un-negated minterm. Applying the
          // mask on x is what makes this an NPN transform of the table.
          shadow_d[idx_q] = y ^ out_neg_q;
          if (idx_q == 4'd15) begin
            // tt and match are loaded on the edge that enters DONE, so they
            // are already valid while done is high.
            tt_d    = shadow_d;
`ifdef NPN_TT_SEQUENCER_CMP_EN
            match_d = (shadow_d == exp_q);
`endif
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = FIRST_PHASE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    // This way every flop samples its pre-edge value.
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      settle_q  <= 4'd0;
      mask_q    <= 4'd0;
      out_neg_q <= 1'b0;
      // NOTE: the 16-entry shadow table is plain flops, not a RAM. Because of
      // that it can be reset, and it is, so a scan never sees stale bits.
      shadow_q  <= '0;
      tt_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      mask_q    <= mask_d;
      out_neg_q <= out_neg_d;
      shadow_q  <= shadow_d;
      tt_q      <= tt_d;
    end
  end

`ifdef NPN_TT_SEQUENCER_CMP_EN
  // Expected-table latch and comparison result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

  // Outputs are decoded from the registered state. A reset therefore clears
  // x and busy immediately.
  assign busy = (state_q == DRIVE) || (state_q == SAMPLE);
  assign x    = busy ? (idx_q ^ mask_q) : 4'd0;
  assign done = (state_q == DONE);
  assign tt   = tt_q;

endmodule

// File: tb/tb_npn_tt_sequencer.sv
// Testbench for npn_tt_sequencer. It drives two instances: u_dut0 with
// SETTLE=1 and u_dut1 with SETTLE=0. Each instance sees its own modelled
// external function, and its outputs are compared against a reference model
// built from truth tables.
module tb_npn_tt_sequencer;

  logic              clk;
  logic              rst_n;
  logic [1:0]        start_v;
  logic [1:0]        abort_v;
  logic [1:0][3:0]   mask_v;
  logic [1:0]        out_neg_v;
  logic [1:0][3:0]   x_v;
  logic [1:0]        y_v;
  logic [1:0]        busy_v;
  logic [1:0]        done_v;
  logic [1:0][15:0]  tt_v;
  logic [1:0][15:0]  fn_v;
`ifdef NPN_TT_SEQUENCER_CMP_EN
  logic [1:0][15:0]  exp_in_v;
  logic [1:0]        match_v;
  logic              exp_match_m [2];
`endif

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_tt_m [2];

  // External function under test: combinational lookup of x in its table.
  assign y_v = {fn_v[1][x_v[1]], fn_v[0][x_v[0]]};

  npn_tt_sequencer #(.SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .neg_mask(mask_v[0]), .out_neg(out_neg_v[0]), .x(x_v[0]), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .tt(tt_v[0])
`ifdef NPN_TT_SEQUENCER_CMP_EN
    , .exp_tt(exp_in_v[0]), .match(match_v[0])
`endif
  );

  npn_tt_sequencer #(.SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .neg_mask(mask_v[1]), .out_neg(out_neg_v[1]), .x(x_v[1]), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .tt(tt_v[1])
`ifdef NPN_TT_SEQUENCER_CMP_EN
    , .exp_tt(exp_in_v[1]), .match(match_v[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Reference: entry i of the table is f(i ^ mask) ^ out_neg.
  function automatic logic [15:0] model_tt(input logic [15:0] fn, input logic [3:0] mask,
                                           input logic oneg);
    logic [15:0] r;
    logic [3:0]  j;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      j = 4'(i) ^ mask;
      r[i] = fn[j] ^ oneg;
    end
    return r;
  endfunction

  function automatic logic [15:0] table_of_maj013();
    logic [15:0] r;
    int a, b, c;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      a = i & 1; b = (i >> 1) & 1; c = (i >> 3) & 1;
      r[i] = (a + b + c) >= 2;
    end
    return r;
  endfunction

  // One scan on instance d. abort_at and noise_m are observation indices m,
  // or -1 for none. The value observed at m is the DUT state after edge k+m,
  // where edge k accepted start.
  task automatic run_scan(input int d, input logic [15:0] fn, input logic [3:0] mask,
                          input logic oneg, input logic [15:0] exp_cmp,
                          input int abort_at, input int noise_m);
    int s, n;
    bit aborts, aborted, noise_ok;
    logic [15:0] model;
    s = settle_of(d);
    n = 16 * (s + 1);
    model = model_tt(fn, mask, oneg);
    aborts = (abort_at >= 0) && (abort_at < n);
    noise_ok = (noise_m >= 0) && (noise_m <= n) && !(aborts && noise_m > abort_at);

    @(negedge clk);
    fn_v[d] = fn;
    mask_v[d] = mask;
    out_neg_v[d] = oneg;
    start_v[d] = 1'b1;
    abort_v[d] = 1'($urandom_range(0, 1));
`ifdef NPN_TT_SEQUENCER_CMP_EN
    exp_in_v[d] = exp_cmp;
`endif
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    abort_v[d] = 1'b0;
    // These are no longer latched, so scrambling them must not matter.
    mask_v[d] = 4'($urandom);
    out_neg_v[d] = 1'($urandom);
`ifdef NPN_TT_SEQUENCER_CMP_EN
    exp_in_v[d] = 16'($urandom);
`endif

    for (int m = 0; m <= n + 1; m++) begin
      aborted = aborts && (m > abort_at);
      if (m == n && !aborted) exp_tt_m[d] = model;
      check($sformatf("busy[d%0d m%0d]", d, m), busy_v[d], !aborted && (m < n));
      check($sformatf("done[d%0d m%0d]", d, m), done_v[d], !aborted && (m == n));
      check($sformatf("tt[d%0d m%0d]", d, m), tt_v[d], exp_tt_m[d]);
      if (!aborted && m < n)
        check($sformatf("x[d%0d m%0d]", d, m), x_v[d], 4'(m / (s + 1)) ^ mask);
      else
        check($sformatf("x_idle[d%0d m%0d]", d, m), x_v[d], 4'd0);
`ifdef NPN_TT_SEQUENCER_CMP_EN
      if (m == n && !aborted) exp_match_m[d] = (model == exp_cmp);
      check($sformatf("match[d%0d m%0d]", d, m), match_v[d], exp_match_m[d]);
`endif
      abort_v[d] = (m == abort_at);
      start_v[d] = noise_ok && (m == noise_m);
      if (start_v[d]) mask_v[d] = 4'($urandom);
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    abort_v[d] = 1'b0;
  endtask

  logic [15:0] and4, maj, fn_r;
  int          ab, nz, n;

  initial begin
    n_checks = 0;
    n_errors = 0;
    start_v = '0; abort_v = '0; mask_v = '0; out_neg_v = '0; fn_v = '0;
    exp_tt_m[0] = '0; exp_tt_m[1] = '0;
`ifdef NPN_TT_SEQUENCER_CMP_EN
    exp_in_v = '0;
    exp_match_m[0] = 1'b0; exp_match_m[1] = 1'b0;
`endif
    and4 = 16'h8000;
    maj  = table_of_maj013();

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_x", x_v[d], 4'd0);
      check("rst_busy", busy_v[d], 1'b0);
      check("rst_done", done_v[d], 1'b0);
      check("rst_tt", tt_v[d], 16'h0000);
`ifdef NPN_TT_SEQUENCER_CMP_EN
      check("rst_match", match_v[d], 1'b0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Majority of x0,x1,x3. SETTLE=1: done is high 32 cycles after start.
    run_scan(0, maj, 4'h0, 1'b0, 16'h0000, -1, -1);
    check("maj_tt", tt_v[0], 16'hEE88);

    // AND4 with every input negated. x walks F..0.
    run_scan(0, and4, 4'hF, 1'b0, 16'h0000, -1, 9);
    check("and4_negall_tt", tt_v[0], 16'h0001);

    // Constant-0 function with output negation, SETTLE=0. A start pulse
    // while busy and another in the DONE cycle must both be ignored.
    run_scan(1, 16'h0000, 4'h3, 1'b1, 16'h0000, -1, 5);
    check("const0_neg_tt", tt_v[1], 16'hFFFF);
    run_scan(1, 16'h0000, 4'h0, 1'b1, 16'h0000, -1, 16);

    // Abort at idx 7 leaves tt at 8000, and the next start runs a full scan.
    run_scan(0, and4, 4'h0, 1'b0, 16'h0000, -1, -1);
    check("pre_abort_tt", tt_v[0], 16'h8000);
    run_scan(0, 16'hFFFF, 4'h0, 1'b0, 16'h0000, 14, -1);
    check("post_abort_tt", tt_v[0], 16'h8000);
    run_scan(1, 16'h5555, 4'h0, 1'b0, 16'h0000, 7, 3);
    run_scan(0, 16'h1234, 4'h5, 1'b0, 16'h0000, -1, -1);
    check("after_abort_scan_tt", tt_v[0], model_tt(16'h1234, 4'h5, 1'b0));

    // Asynchronous reset while idx=10. It takes effect mid-cycle, with no done.
    @(negedge clk);
    fn_v[0] = 16'hFFFF; mask_v[0] = 4'h0; out_neg_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int m = 0; m < 20; m++) begin
      check("rst_scan_done", done_v[0], 1'b0);
      @(negedge clk);
    end
    check("pre_rst_x", x_v[0], 4'hA);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x", x_v[0], 4'd0);
    check("async_rst_busy", busy_v[0], 1'b0);
    check("async_rst_done", done_v[0], 1'b0);
    check("async_rst_tt0", tt_v[0], 16'h0000);
    check("async_rst_tt1", tt_v[1], 16'h0000);
    exp_tt_m[0] = '0; exp_tt_m[1] = '0;
`ifdef NPN_TT_SEQUENCER_CMP_EN
    exp_match_m[0] = 1'b0; exp_match_m[1] = 1'b0;
`endif
    @(negedge clk);
    check("rst_hold_done", done_v[0], 1'b0);
    rst_n = 1'b1;
    run_scan(0, maj, 4'h6, 1'b1, 16'h0000, -1, -1);

    // Comparator: AND4 matches 8000 but not 8001.
    run_scan(0, and4, 4'h0, 1'b0, 16'h8000, -1, -1);
    run_scan(0, and4, 4'h0, 1'b0, 16'h8001, -1, -1);
    run_scan(1, and4, 4'h0, 1'b0, 16'h8000, 4, -1);

    // Randomised scans on both settle settings.
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < 2; d++) begin
        n = 16 * (settle_of(d) + 1);
        fn_r = 16'($urandom);
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
        nz = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, n)) : -1;
        run_scan(d, fn_r, 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? model_tt(fn_r, mask_v[d], 1'b0) : 16'($urandom),
                 ab, nz);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/npn_tt_sequencer.md
NPN_TT_SEQUENCER -- requirements
Module: npn_tt_sequencer

Interface
REQ-001 SHALL have parameter: SETTLE, default 1, number of wait cycles per minterm before y is sampled (legal 0..15).
REQ-002 SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  in  1  scan request, sampled only in IDLE.
REQ-005 SHALL have port: abort  in  1  cancels an in-progress scan.
REQ-006 SHALL have port: neg_mask  in  4  input-negation mask, latched at start.
REQ-007 SHALL have port: out_neg  in  1  output-negation flag, latched at start.
REQ-008 SHALL have port: x  out  4  drives the inputs of the external 4-input function under test; x[0]->x0 through x[3]->x3.
REQ-009 SHALL have port: y  in  1  output of the external function, combinational from x.
REQ-010 SHALL have port: busy  out  1  high while a scan is in progress.
REQ-011 SHALL have port: done  out  1  one-cycle pulse when a scan completes.
REQ-012 SHALL have port: tt  out  16  last completed truth table; bit i is the result for minterm i.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-014 IDLE: x=0 and busy=0; start=1 latches neg_mask and out_neg, clears the minterm index idx to 0, and moves to DRIVE.
REQ-015 DRIVE/SAMPLE: x SHALL equal idx XOR latched neg_mask, held stable for all SETTLE+1 cycles of the minterm.
REQ-016 DRIVE SHALL last SETTLE cycles, counted by a settle counter; SETTLE=0 skips DRIVE and goes directly to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and write shadow[idx] = y XOR latched out_neg, indexed by the un-negated idx.
REQ-018 After SAMPLE, idx<15 SHALL increment idx (4-bit) and go to DRIVE; idx=15 SHALL go to DONE without wrapping.
REQ-019 DONE SHALL last one cycle, assert done=1, copy shadow to tt, and return to IDLE.
REQ-020 tt SHALL remain unchanged during a scan and change only in the DONE cycle.
REQ-021 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-022 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+16*(SETTLE+1); for SETTLE=1 that is 32 cycles.
REQ-023 start SHALL be ignored in DRIVE, SAMPLE and DONE; a new scan can begin at the earliest from IDLE on the cycle after done.
REQ-024 abort=1 in DRIVE or SAMPLE SHALL return to IDLE at the next edge, with no done, tt unchanged and shadow discarded; abort has priority over a same-cycle SAMPLE write.
REQ-025 abort SHALL be ignored in IDLE and DONE; if start and abort are both high in IDLE, start SHALL be accepted.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: IDLE, x=0, busy=0, done=0, tt=0, idx=0, settle counter=0, latched mask/flag=0, shadow=0.
REQ-027 Reset asserted mid-scan SHALL abandon the scan with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-028 Macro NPN_TT_SEQUENCER_CMP_EN, when defined, SHALL add input exp_tt (16 bits, latched at start) and output match (1 bit, reset 0).
REQ-029 With NPN_TT_SEQUENCER_CMP_EN defined, match SHALL update in the DONE cycle to (shadow == latched exp_tt) and hold until the next DONE; abort SHALL leave match unchanged.
REQ-030 Without NPN_TT_SEQUENCER_CMP_EN, exp_tt, match and the comparator SHALL be absent; all other behaviour is identical.

Verification
REQ-031 y=maj(x0,x1,x3), mask=0, out_neg=0, SETTLE=1 -> done exactly 32 cycles after start; tt=16'hEE88; busy high for 32 cycles.
REQ-032 y=x0&x1&x2&x3, mask=4'hF, out_neg=0 -> tt=16'h0001; x sequence observed is F,E,D,...,0.
REQ-033 y=0, out_neg=1, SETTLE=0 -> tt=16'hFFFF with done 16 cycles after start; start pulsed while busy -> ignored, exactly one done.
REQ-034 After tt=16'h8000, start a scan and assert abort at idx=7 -> busy low next cycle, no done, tt stays 16'h8000, next start runs a full scan.
REQ-035 rst_n low at idx=10 -> x=0, busy=0, tt=0 immediately (asynchronous), no done pulse.
REQ-036 With NPN_TT_SEQUENCER_CMP_EN: AND4 with exp_tt=16'h8000 -> match=1; rescan with exp_tt=16'h8001 -> match=0 in the DONE cycle.
